ingress_pkt_buffer: RTL and testbench



---
 rtl/ingress_pkg.sv | 34 +++
 rtl/ingress_pkt_ram.sv | 29 ++
 rtl/ingress_pkt_buffer.sv | 215 +++++++++++++++++++++
 tb/tb_ingress_pkt_buffer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ingress_pkg.sv
// ingress_pkg: shared constants, input FSM state type and the header
// length helper used by the ingress packet buffer.
//   FEP_HEADER          constant written over the first beat's MAC field
//   IPV4_TYPE/IPV6_TYPE EtherTypes accepted by the header check
//   *_LENGTH_OFFSET     added to the IP length field to form frame length L
//   in_state_t          input-side FSM states
//   frame_length()      L from the first-beat header fields
package ingress_pkg;

  localparam logic [47:0] FEP_HEADER         = 48'h1EAD_FEB5_AC0D;
  localparam logic [15:0] IPV4_TYPE          = 16'h0800;
  localparam logic [15:0] IPV6_TYPE          = 16'h86DD;
  localparam logic [16:0] IPV4_LENGTH_OFFSET = 17'd18;
  localparam logic [16:0] IPV6_LENGTH_OFFSET = 17'd58;

  typedef enum logic [1:0] {
    IN_IDLE,
    IN_STORE,
    IN_DROP
  } in_state_t;

  // Unsupported EtherTypes yield 0, which never clears the exclusive
  // lower length bound, so a single range test covers both checks.
  function automatic logic [16:0] frame_length(input logic [15:0] ether_type,
                                               input logic [15:0] v4_len,
                                               input logic [15:0] v6_len);
    logic [16:0] len;
    len = '0;
    if (ether_type == IPV4_TYPE)      len = {1'b0, v4_len} + IPV4_LENGTH_OFFSET;
    else if (ether_type == IPV6_TYPE) len = {1'b0, v6_len} + IPV6_LENGTH_OFFSET;
    return len;
  endfunction

endpackage

// File: rtl/ingress_pkt_ram.sv
// ingress_pkt_ram: simple dual-port synchronous RAM, one write and one
// read port, registered read data (1-cycle latency). rd_data only changes
// when rd_en is high, so it can serve directly as an output register.
//   clk      sole clock
//   wr_en    write strobe, wr_addr / wr_data write address and word
//   rd_en    read strobe, rd_addr read address
//   rd_data  registered read word
module ingress_pkt_ram #(
  parameter int unsigned WIDTH = 577,
  parameter int unsigned DEPTH = 64,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ingress_pkt_buffer.sv
// ingress_pkt_buffer: store-and-forward ingress buffer. Header-checks each
// frame, rewrites the MAC field of the first beat with the FEP header and
// the packet length, and only exposes complete packets downstream.
// Overflowing (and, with INGRESS_LEN_CHECK_EN defined, length-mismatched)
// packets are rolled back and dropped whole.
//   clk, rst                 clock, synchronous active-high reset
//   s_axis_*                 MRMAC input stream (tready 0 only in reset)
//   m_axis_*                 buffered output stream
//   pkt_cnt                  committed packets (saturating)
//   drop_hdr_cnt             header-check drops (saturating)
//   drop_ovf_cnt             overflow drops (saturating)
//   drop_len_cnt             length-mismatch drops (0 unless INGRESS_LEN_CHECK_EN)
//   fill_level               committed beats held, including the output beat
module ingress_pkt_buffer #(
  parameter int unsigned DATA_WIDTH     = 512,
  parameter int unsigned DEPTH_BEATS    = 64,
  parameter int unsigned MIN_PKT_LENGTH = 63,
  parameter int unsigned MAX_PKT_LENGTH = 1519
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]       s_axis_tkeep,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]       m_axis_tkeep,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic [31:0]                   pkt_cnt,
  output logic [31:0]                   drop_hdr_cnt,
  output logic [31:0]                   drop_ovf_cnt,
  output logic [31:0]                   drop_len_cnt,
  output logic [$clog2(DEPTH_BEATS):0]  fill_level
);
  import ingress_pkg::*;

  localparam int unsigned KW = DATA_WIDTH / 8;
  localparam int unsigned AW = $clog2(DEPTH_BEATS);
  localparam int unsigned PW = AW + 1;

  // Entry layout lives here because packages cannot take parameters.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KW-1:0]         keep;
    logic                  last;
  } entry_t;

  in_state_t     state_q, state_d;
  logic [PW-1:0] wr_ptr_spec, spec_d, wr_ptr_cmt, cmt_d, rd_ptr, rd_addr;
  logic          ready_q, beat_in, full, hdr_ok, store, len_bad;
  logic          inc_pkt, inc_hdr, inc_ovf, rd_en, out_valid;
  logic [16:0]   frame_len;
  logic [15:0]   pkt_len;
  logic [31:0]   pkt_q, hdr_q, ovf_q;
  entry_t        wr_entry, rd_entry;

  assign beat_in   = s_axis_tvalid && ready_q;
  assign frame_len = frame_length({s_axis_tdata[103:96], s_axis_tdata[111:104]},
                                  {s_axis_tdata[135:128], s_axis_tdata[143:136]},
                                  {s_axis_tdata[151:144], s_axis_tdata[159:152]});
  assign hdr_ok    = (frame_len > 17'(MIN_PKT_LENGTH)) && (frame_len < 17'(MAX_PKT_LENGTH));
  assign pkt_len   = frame_len[15:0] - 16'd4;
  // rd_ptr only advances on output handshake, so a beat sitting in the
  // output register still occupies its slot.
  assign full      = (wr_ptr_spec - rd_ptr) == PW'(DEPTH_BEATS);

  always_comb begin
    state_d  = state_q;
    spec_d   = wr_ptr_spec;
    cmt_d    = wr_ptr_cmt;
    store    = 1'b0;
    inc_pkt  = 1'b0;
    inc_hdr  = 1'b0;
    inc_ovf  = 1'b0;
    wr_entry = '{data: s_axis_tdata, keep: s_axis_tkeep, last: s_axis_tlast};
    if (beat_in) begin
      unique case (state_q)
        IN_IDLE: begin
          wr_entry.data[95:0] = {FEP_HEADER, pkt_len, pkt_len, pkt_len};
          if (!hdr_ok) begin
            inc_hdr = 1'b1;
            if (!s_axis_tlast) state_d = IN_DROP;
          end else if (full) begin
            inc_ovf = 1'b1;
            if (!s_axis_tlast) state_d = IN_DROP;
          end else begin
            store = 1'b1;
          end
        end
        IN_STORE: begin
          if (full) begin
            inc_ovf = 1'b1;
            spec_d  = wr_ptr_cmt;
            state_d = s_axis_tlast ? IN_IDLE : IN_DROP;
          end else begin
            store = 1'b1;
          end
        end
        IN_DROP: if (s_axis_tlast) state_d = IN_IDLE;
        default: state_d = IN_IDLE;
      endcase
      if (store) begin
        spec_d = wr_ptr_spec + PW'(1);
        if (!s_axis_tlast) begin
          state_d = IN_STORE;
        end else begin
          state_d = IN_IDLE;
          if (len_bad) begin
            spec_d = wr_ptr_cmt;
          end else begin
            cmt_d   = wr_ptr_spec + PW'(1);
            inc_pkt = 1'b1;
          end
        end
      end
    end
  end

`ifdef INGRESS_LEN_CHECK_EN
  logic [31:0] rx_q, rx_total, drop_len_q;
  logic [15:0] len_q, len_ref;
  logic        inc_len;

  function automatic logic [31:0] keep_bytes(input logic [KW-1:0] keep);
    logic [31:0] n;
    n = '0;
    for (int unsigned i = 0; i < KW; i++) if (keep[i]) n = i + 1;
    return n;
  endfunction

  always_comb begin
    rx_total = ((state_q == IN_IDLE) ? 32'd0 : rx_q)
             + (s_axis_tlast ? keep_bytes(s_axis_tkeep) : 32'(KW));
    len_ref  = (state_q == IN_IDLE) ? pkt_len : len_q;
    len_bad  = rx_total != {16'd0, len_ref};
    inc_len  = store && s_axis_tlast && len_bad;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q       <= '0;
      len_q      <= '0;
      drop_len_q <= '0;
    end else begin
      if (store) rx_q <= rx_total;
      if (beat_in && state_q == IN_IDLE) len_q <= pkt_len;
      if (inc_len && drop_len_q != '1) drop_len_q <= drop_len_q + 32'd1;
    end
  end

  assign drop_len_cnt = drop_len_q;
`else
  assign len_bad      = 1'b0;
  assign drop_len_cnt = '0;
`endif

  // The RAM's registered read port is the output register: a read is only
  // issued when that register is empty or being consumed, which keeps
  // m_axis stable under backpressure while sustaining one beat per cycle.
  assign rd_en = (rd_addr != wr_ptr_cmt) && (!out_valid || m_axis_tready);

  ingress_pkt_ram #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH_BEATS)
  ) u_ram (
    .clk     (clk),
    .wr_en   (store),
    .wr_addr (wr_ptr_spec[AW-1:0]),
    .wr_data (wr_entry),
    .rd_en   (rd_en),
    .rd_addr (rd_addr[AW-1:0]),
    .rd_data (rd_entry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IN_IDLE;
      ready_q     <= 1'b0;
      wr_ptr_spec <= '0;
      wr_ptr_cmt  <= '0;
      rd_ptr      <= '0;
      rd_addr     <= '0;
      out_valid   <= 1'b0;
      pkt_q       <= '0;
      hdr_q       <= '0;
      ovf_q       <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= 1'b1;
      wr_ptr_spec <= spec_d;
      wr_ptr_cmt  <= cmt_d;
      if (rd_en) rd_addr <= rd_addr + PW'(1);
      if (out_valid && m_axis_tready) rd_ptr <= rd_ptr + PW'(1);
      if (rd_en)              out_valid <= 1'b1;
      else if (m_axis_tready) out_valid <= 1'b0;
      if (inc_pkt && pkt_q != '1) pkt_q <= pkt_q + 32'd1;
      if (inc_hdr && hdr_q != '1) hdr_q <= hdr_q + 32'd1;
      if (inc_ovf && ovf_q != '1) ovf_q <= ovf_q + 32'd1;
    end
  end

  assign s_axis_tready = ready_q;
  assign m_axis_tvalid = out_valid;
  assign m_axis_tdata  = rd_entry.data;
  assign m_axis_tkeep  = rd_entry.keep;
  assign m_axis_tlast  = rd_entry.last;
  assign pkt_cnt       = pkt_q;
  assign drop_hdr_cnt  = hdr_q;
  assign drop_ovf_cnt  = ovf_q;
  assign fill_level    = wr_ptr_cmt - rd_ptr;

endmodule

// File: tb/tb_ingress_pkt_buffer.sv
`timescale 1ns/1ps
module tb_ingress_pkt_buffer;

  localparam int unsigned DW    = 512;
  localparam int unsigned KW    = DW / 8;
  localparam int          DEPTH = 64;
`ifdef INGRESS_LEN_CHECK_EN
  localparam bit LEN_CHECK = 1'b1;
`else
  localparam bit LEN_CHECK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tvalid, m_axis_tlast;
  logic          m_axis_tready = 1'b0;
  logic [31:0]   pkt_cnt, drop_hdr_cnt, drop_ovf_cnt, drop_len_cnt;
  logic [6:0]    fill_level;

  always #5 clk = ~clk;

  ingress_pkt_buffer #(
    .DATA_WIDTH     (DW),
    .DEPTH_BEATS    (DEPTH),
    .MIN_PKT_LENGTH (63),
    .MAX_PKT_LENGTH (1519)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .pkt_cnt       (pkt_cnt),
    .drop_hdr_cnt  (drop_hdr_cnt),
    .drop_ovf_cnt  (drop_ovf_cnt),
    .drop_len_cnt  (drop_len_cnt),
    .fill_level    (fill_level)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [639:0] got, input logic [639:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state: expected output beats {last, keep, data} and
  // packet-level outcome counters.
  logic [576:0] exp_q[$];
  int           committed_beats = 0, out_beats = 0;
  int unsigned  exp_pkt = 0, exp_hdr = 0, exp_ovf = 0, exp_len = 0;
  int unsigned  ready_mode = 1;  // 0: stall, 1: always ready, 2: random
  logic [DW-1:0] pd [32];
  logic [KW-1:0] pk [32];

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       m_axis_tready = 1'b0;
      1:       m_axis_tready = 1'b1;
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
  end

  // Output monitor: holds under stall and in-order beat contents.
  logic [577:0] prev_beat;
  bit           prev_stall = 1'b0;
  always @(negedge clk) begin
    logic [577:0] cur;
    cur = {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check_eq("axis_hold", cur, prev_beat);
      if (m_axis_tvalid && m_axis_tready) begin
        out_beats++;
        check_eq("beat_expected", 640'(exp_q.size() != 0), 640'(1));
        if (exp_q.size() != 0) check_eq("beat", cur[576:0], exp_q.pop_front());
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = cur;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  function automatic int frame_len_model(input logic [15:0] etype, input logic [15:0] lf);
    if (etype == 16'h0800) return int'(lf) + 18;
    if (etype == 16'h86DD) return int'(lf) + 58;
    return -1;
  endfunction

  task automatic build_pkt(input logic [15:0] etype, input logic [15:0] lf,
                           input int unsigned n, input int unsigned lastb);
    for (int unsigned b = 0; b < n; b++) begin
      for (int unsigned w = 0; w < DW / 32; w++) pd[b][32*w +: 32] = $urandom;
      pk[b] = '1;
    end
    pd[0][103:96] = etype[15:8];
    pd[0][111:104] = etype[7:0];
    if (etype == 16'h86DD) begin
      pd[0][151:144] = lf[15:8];
      pd[0][159:152] = lf[7:0];
    end else begin
      pd[0][135:128] = lf[15:8];
      pd[0][143:136] = lf[7:0];
    end
    for (int unsigned i = 0; i < KW; i++) pk[n-1][i] = (i < lastb);
  endtask

  task automatic drive_beat(input int unsigned b, input bit last);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = pd[b];
    s_axis_tkeep  = pk[b];
    s_axis_tlast  = last;
    sync();
  endtask

  task automatic send_pkt(input logic [15:0] etype, input logic [15:0] lf,
                          input int unsigned n, input int unsigned lastb, input bit gaps);
    int           len, held, rx;
    logic [15:0]  plen;
    logic [576:0] e;
    build_pkt(etype, lf, n, lastb);
    len  = frame_len_model(etype, lf);
    held = committed_beats - out_beats;
    plen = 16'(len - 4);
    rx   = 64 * (int'(n) - 1) + int'(lastb);
    if (!(len > 63 && len < 1519)) exp_hdr++;
    else if (int'(n) > DEPTH - held) exp_ovf++;
    else if (LEN_CHECK && rx != int'(plen)) exp_len++;
    else begin
      for (int unsigned b = 0; b < n; b++) begin
        e = {(b == n - 1), pk[b], pd[b]};
        if (b == 0) e[95:0] = {48'h1EADFEB5AC0D, plen, plen, plen};
        exp_q.push_back(e);
      end
      exp_pkt++;
      committed_beats += int'(n);
    end
    for (int unsigned b = 0; b < n; b++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_axis_tvalid = 1'b0;
        sync();
      end
      drive_beat(b, b == n - 1);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic check_counters(input string tag);
    check_eq({tag, "_pkt_cnt"}, pkt_cnt, exp_pkt);
    check_eq({tag, "_drop_hdr"}, drop_hdr_cnt, exp_hdr);
    check_eq({tag, "_drop_ovf"}, drop_ovf_cnt, exp_ovf);
    check_eq({tag, "_drop_len"}, drop_len_cnt, exp_len);
    check_eq({tag, "_fill"}, fill_level, committed_beats - out_beats);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check_eq({tag, "_drain"}, exp_q.size(), 0);
  endtask

  // Boundary table: {etype, length field, beats, last-beat bytes}
  logic [15:0] bt_type [7] = '{16'h0800, 16'h0800, 16'h0800, 16'h0800, 16'h86DD, 16'h86DD, 16'h86DD};
  logic [15:0] bt_len  [7] = '{16'd45,   16'd46,   16'd1500, 16'd1501, 16'd6,    16'd1460, 16'd1500};
  int unsigned bt_n    [7] = '{1, 1, 24, 2, 1, 24, 3};
  int unsigned bt_lb   [7] = '{59, 60, 42, 10, 60, 42, 8};

  initial begin
    int unsigned t, plen, n, lb, kind, sel, out_before;
    rst           = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("tready_in_reset", s_axis_tready, 0);
    sync();
    rst = 1'b0;
    repeat (2) sync();
    check_eq("tready_after_reset", s_axis_tready, 1);
    check_eq("tvalid_after_reset", m_axis_tvalid, 0);
    check_counters("reset");

    // IPv4 total length 100 -> pkt_len 114 across 2 beats
    send_pkt(16'h0800, 16'd100, 2, 50, 0);
    wait_drain("ipv4");
    check_counters("ipv4");

    // Unsupported EtherType, then a good packet
    send_pkt(16'h0806, 16'd100, 2, 50, 0);
    send_pkt(16'h0800, 16'd100, 2, 50, 0);
    wait_drain("arp");
    check_counters("arp");

    for (int i = 0; i < 7; i++) send_pkt(bt_type[i], bt_len[i], bt_n[i], bt_lb[i], 0);
    wait_drain("bounds");
    check_counters("bounds");

    // Overflow: stalled output, three 24-beat packets
    ready_mode = 0;
    sync();
    for (int i = 0; i < 3; i++) send_pkt(16'h0800, 16'd1500, 24, 42, 0);
    repeat (3) sync();
    check_eq("ovf_fill_48", fill_level, 48);
    check_counters("ovf");
    out_before = out_beats;
    ready_mode = 1;
    wait_drain("ovf");
    check_eq("ovf_beats_out", out_beats - out_before, 48);
    check_counters("ovf_done");

    // Header says 114 bytes, frame carries three beats
    send_pkt(16'h0800, 16'd100, 3, 64, 0);
    wait_drain("lenchk");
    check_counters("lenchk");

    // Randomised traffic with random backpressure
    ready_mode = 2;
    for (int p = 0; p < 40; p++) begin
      for (int w = 0; w < 2000 && (committed_beats - out_beats + 25 > DEPTH - 2); w++) sync();
      kind = $urandom_range(0, 9);
      if (kind < 5) begin
        t = $urandom_range(46, 1500);
        plen = t + 14; n = (plen + 63) / 64; lb = plen - 64 * (n - 1);
        send_pkt(16'h0800, 16'(t), n, lb, 1);
      end else if (kind < 7) begin
        t = $urandom_range(6, 1460);
        plen = t + 54; n = (plen + 63) / 64; lb = plen - 64 * (n - 1);
        send_pkt(16'h86DD, 16'(t), n, lb, 1);
      end else if (kind == 7) begin
        sel = $urandom_range(0, 2);
        n = $urandom_range(1, 4); lb = $urandom_range(1, 64);
        if (sel == 0)      send_pkt(16'h0806, 16'($urandom_range(46, 1500)), n, lb, 1);
        else if (sel == 1) send_pkt(16'h0800, 16'($urandom_range(0, 45)), n, lb, 1);
        else               send_pkt(16'h0800, 16'($urandom_range(1501, 4000)), n, lb, 1);
      end else begin
        t = $urandom_range(46, 1400);
        plen = t + 14; n = (plen + 63) / 64; lb = plen - 64 * (n - 1);
        send_pkt(16'h0800, 16'(t), n + 1, lb, 1);
      end
    end
    wait_drain("random");
    check_counters("random");

    // Reset in the middle of a 10-beat packet
    ready_mode = 1;
    build_pkt(16'h0800, 16'd1500, 10, 64);
    for (int unsigned b = 0; b < 4; b++) drive_beat(b, 1'b0);
    rst = 1'b1;
    drive_beat(4, 1'b0);
    s_axis_tvalid = 1'b0;
    sync();
    rst = 1'b0;
    exp_q.delete();
    committed_beats = 0; out_beats = 0;
    exp_pkt = 0; exp_hdr = 0; exp_ovf = 0; exp_len = 0;
    repeat (3) sync();
    check_eq("rst_tvalid", m_axis_tvalid, 0);
    check_eq("rst_tready", s_axis_tready, 1);
    check_counters("rst");
    send_pkt(16'h0800, 16'd100, 2, 50, 0);
    @(negedge clk);
    check_eq("latency_cycle1_tvalid", m_axis_tvalid, 0);
    @(posedge clk);
    @(negedge clk);
    check_eq("latency_cycle2_tvalid", m_axis_tvalid, 1);
    sync();
    wait_drain("post_rst");
    check_counters("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
